// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame clear/draw/swap scheduler for the double-buffered display
//
// Each frame the back buffer (~front_sel) is cleared to CLEAR_COLOR. The write
// port is then handed to the raster engine until draw_done. The buffers swap
// on the first VSync rising edge after that. A VSync edge that arrives while
// clearing or drawing is counted as a missed frame and does not cause a swap.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   VSync                   vertical sync level; rising edge = frame boundary
//   draw_start              one-cycle pulse on the first DRAW cycle
//   draw_done               raster engine finished (honoured only in DRAW)
//   draw_we/addr/data       raster write request, forwarded only in DRAW
//   fb_we/addr/data         registered back-buffer write port
//   front_sel               buffer being scanned out
//   busy                    high while clearing or drawing
//   frame_count             completed swaps, wrapping
//   missed_count            late VSync edges, saturating

module frame_sequencer #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 9,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              VSync,
  output logic              draw_start,
  input  logic              draw_done,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [PIX_W-1:0]  draw_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  output logic              front_sel,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [15:0]       missed_count
);

  localparam int N = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAW  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              vsync_q;
  logic              vsync_rise;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nxt;
  logic              fb_we_nxt;
  logic [ADDR_W-1:0] fb_addr_nxt;
  logic [PIX_W-1:0]  fb_data_nxt;
  logic              draw_start_nxt;
  logic              front_sel_nxt;
  logic              busy_nxt;
  logic [15:0]       frame_count_nxt;
  logic [15:0]       missed_count_nxt;

  assign vsync_rise = VSync & ~vsync_q;

  // State and every registered output. All registers load their next value
  // every cycle so that holding is expressed only in the combinational logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      vsync_q      <= 1'b0;
      clr_cnt      <= '0;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      draw_start   <= 1'b0;
      front_sel    <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= '0;
      missed_count <= '0;
    end else begin
      state        <= state_nxt;
      vsync_q      <= VSync;
      clr_cnt      <= clr_cnt_nxt;
      fb_we        <= fb_we_nxt;
      fb_addr      <= fb_addr_nxt;
      fb_data      <= fb_data_nxt;
      draw_start   <= draw_start_nxt;
      front_sel    <= front_sel_nxt;
      busy         <= busy_nxt;
      frame_count  <= frame_count_nxt;
      missed_count <= missed_count_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_CLEAR;
      S_CLEAR: if (clr_cnt == LAST_PIX) state_nxt = S_DRAW;
      S_DRAW:  if (draw_done) state_nxt = S_WAIT;
      S_WAIT:  if (vsync_rise) state_nxt = S_CLEAR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    clr_cnt_nxt      = clr_cnt;
    fb_we_nxt        = 1'b0;
    fb_addr_nxt      = fb_addr;
    fb_data_nxt      = fb_data;
    draw_start_nxt   = 1'b0;
    front_sel_nxt    = front_sel;
    frame_count_nxt  = frame_count;
    missed_count_nxt = missed_count;
    busy_nxt         = (state_nxt == S_CLEAR) || (state_nxt == S_DRAW);

    case (state)
      S_IDLE: begin
        clr_cnt_nxt = '0;
      end
      S_CLEAR: begin
        fb_we_nxt   = 1'b1;
        fb_addr_nxt = clr_cnt;
        fb_data_nxt = CLEAR_COLOR;
        clr_cnt_nxt = clr_cnt + 1'b1;
        // The pulse lands on the same cycle the last clear write is visible.
        draw_start_nxt = (clr_cnt == LAST_PIX);
      end
      S_DRAW: begin
        if (draw_we) begin
          fb_we_nxt   = 1'b1;
          fb_addr_nxt = draw_addr;
          fb_data_nxt = draw_data;
        end
      end
      S_WAIT: begin
        if (vsync_rise) begin
          front_sel_nxt   = ~front_sel;
          frame_count_nxt = frame_count + 16'd1;
          clr_cnt_nxt     = '0;
        end
      end
      default: begin
        clr_cnt_nxt = '0;
      end
    endcase

    // A frame boundary while still clearing or drawing is a missed frame.
    if (vsync_rise && ((state == S_CLEAR) || (state == S_DRAW)) &&
        (missed_count != 16'hFFFF)) begin
      missed_count_nxt = missed_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer (4x2 frame)

module tb_frame_sequencer;

  localparam int N = 8;

  logic       clk;
  logic       reset;
  logic       VSync;
  logic       draw_start;
  logic       draw_done;
  logic       draw_we;
  logic [2:0] draw_addr;
  logic [8:0] draw_data;
  logic       fb_we;
  logic [2:0] fb_addr;
  logic [8:0] fb_data;
  logic       front_sel;
  logic       busy;
  logic [15:0] frame_count;
  logic [15:0] missed_count;

  int checks = 0;
  int errors = 0;

  // Reference model of the frame-level counters.
  logic        m_front;
  logic [15:0] m_frames;
  logic [15:0] m_missed;

  frame_sequencer #(
    .WIDTH(4), .HEIGHT(2), .ADDR_W(3), .PIX_W(9), .CLEAR_COLOR(9'h000)
  ) dut (
    .clk(clk), .reset(reset), .VSync(VSync), .draw_start(draw_start),
    .draw_done(draw_done), .draw_we(draw_we), .draw_addr(draw_addr),
    .draw_data(draw_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .front_sel(front_sel), .busy(busy), .frame_count(frame_count),
    .missed_count(missed_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; VSync = 1'b0; draw_done = 1'b0; draw_we = 1'b0;
    draw_addr = '0; draw_data = '0;
    repeat (3) step();
    checks++;
    if ({fb_we, fb_addr, fb_data, draw_start, front_sel, busy} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {fb_we, fb_addr, fb_data, draw_start, front_sel, busy});
    end
    checks++;
    if ({frame_count, missed_count} !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %h expected 0", {frame_count, missed_count});
    end
    // Release with a VSync edge that lands while the sequencer is in IDLE.
    reset = 1'b0; VSync = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++;
      if (fb_we !== (i >= 2)) begin
        errors++;
        $display("FAIL init_clear_we[%0d]: got %b expected %b", i, fb_we, (i >= 2));
      end
      if (i >= 2) begin
        checks++;
        if (fb_addr !== 3'(i - 2) || fb_data !== 9'h000) begin
          errors++;
          $display("FAIL init_clear_addr[%0d]: got %0d/%h expected %0d/000", i, fb_addr, fb_data, i - 2);
        end
      end
      checks++;
      if (draw_start !== (i == 9) || busy !== 1'b1) begin
        errors++;
        $display("FAIL init_start_busy[%0d]: got %b%b expected %b1", i, draw_start, busy, (i == 9));
      end
    end
    checks++;
    if (missed_count !== 16'd0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL idle_edge_ignored: got %0d/%0d expected 0/0", missed_count, frame_count);
    end
    VSync = 1'b0;
  endtask

  task automatic test_draw_writes();
    draw_we = 1'b1; draw_addr = 3'd5; draw_data = 9'h1A3;
    step();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 3'd5 || fb_data !== 9'h1A3) begin
      errors++;
      $display("FAIL draw_wr1: got %b/%0d/%h expected 1/5/1a3", fb_we, fb_addr, fb_data);
    end
    draw_addr = 3'd2; draw_data = 9'h055;
    step();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 3'd2 || fb_data !== 9'h055) begin
      errors++;
      $display("FAIL draw_wr2: got %b/%0d/%h expected 1/2/055", fb_we, fb_addr, fb_data);
    end
    // Write together with done: still forwarded.
    draw_addr = 3'd6; draw_data = 9'h0F0; draw_done = 1'b1;
    step();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 3'd6 || fb_data !== 9'h0F0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL draw_wr_done: got %b/%0d/%h busy %b expected 1/6/0f0 busy 0", fb_we, fb_addr, fb_data, busy);
    end
    draw_done = 1'b0; draw_addr = 3'd1; draw_data = 9'h1FF;
    repeat (3) begin
      step();
      checks++;
      if (fb_we !== 1'b0 || fb_addr !== 3'd6 || fb_data !== 9'h0F0) begin
        errors++;
        $display("FAIL wait_we_ignored: got %b/%0d/%h expected 0/6/0f0", fb_we, fb_addr, fb_data);
      end
    end
    draw_we = 1'b0;
  endtask

  task automatic test_swap();
    VSync = 1'b1;
    step();
    checks++;
    if (front_sel !== 1'b1 || frame_count !== 16'd1 || fb_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL swap_t1: got front %b frames %0d we %b busy %b expected 1 1 0 1", front_sel, frame_count, fb_we, busy);
    end
    for (int i = 2; i <= 9; i++) begin
      step();
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== 3'(i - 2) || draw_start !== (i == 9)) begin
        errors++;
        $display("FAIL swap_clear[%0d]: got %b/%0d start %b expected 1/%0d start %b", i, fb_we, fb_addr, draw_start, i - 2, (i == 9));
      end
    end
    repeat (11) begin
      step();
      checks++;
      if (frame_count !== 16'd1 || front_sel !== 1'b1 || missed_count !== 16'd0 || fb_we !== 1'b0) begin
        errors++;
        $display("FAIL vsync_held: got frames %0d front %b missed %0d we %b expected 1 1 0 0", frame_count, front_sel, missed_count, fb_we);
      end
    end
    VSync = 1'b0;
  endtask

  task automatic test_missed();
    draw_done = 1'b1;
    step();
    draw_done = 1'b0; VSync = 1'b1;
    step();
    VSync = 1'b0;
    checks++;
    if (front_sel !== 1'b0 || frame_count !== 16'd2) begin
      errors++;
      $display("FAIL missed_swap: got front %b frames %0d expected 0 2", front_sel, frame_count);
    end
    step();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 3'd0) begin
      errors++;
      $display("FAIL missed_clear0: got %b/%0d expected 1/0", fb_we, fb_addr);
    end
    VSync = 1'b1;
    for (int i = 3; i <= 9; i++) begin
      step();
      if (i == 3) begin
        VSync = 1'b0;
        checks++;
        if (missed_count !== 16'd1) begin
          errors++;
          $display("FAIL missed_in_clear: got %0d expected 1", missed_count);
        end
      end
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== 3'(i - 2)) begin
        errors++;
        $display("FAIL missed_clear[%0d]: got %b/%0d expected 1/%0d", i, fb_we, fb_addr, i - 2);
      end
    end
    checks++;
    if (draw_start !== 1'b1) begin
      errors++;
      $display("FAIL missed_draw_start: got %b expected 1", draw_start);
    end
    VSync = 1'b1;
    step();
    VSync = 1'b0;
    checks++;
    if (missed_count !== 16'd2 || front_sel !== 1'b0 || frame_count !== 16'd2) begin
      errors++;
      $display("FAIL missed_in_draw: got missed %0d front %b frames %0d expected 2 0 2", missed_count, front_sel, frame_count);
    end
  endtask

  task automatic test_reset_mid();
    draw_done = 1'b1;
    step();
    draw_done = 1'b0; VSync = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      VSync = 1'b0;
    end
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 3'd4) begin
      errors++;
      $display("FAIL mid_pre_addr4: got %b/%0d expected 1/4", fb_we, fb_addr);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({fb_we, front_sel, busy, draw_start} !== 4'd0 || {frame_count, missed_count} !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b%b%b%b %h expected 0000 0", fb_we, front_sel, busy, draw_start, {frame_count, missed_count});
    end
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++;
      if (fb_we !== (i >= 2) || (i >= 2 && fb_addr !== 3'(i - 2)) || draw_start !== (i == 9)) begin
        errors++;
        $display("FAIL mid_restart[%0d]: got %b/%0d start %b expected %b/%0d start %b", i, fb_we, fb_addr, draw_start, (i >= 2), i - 2, (i == 9));
      end
    end
  endtask

  task automatic test_saturate();
    force dut.missed_count = 16'hFFFF;
    force dut.frame_count  = 16'hFFFF;
    step();
    step();
    release dut.missed_count;
    release dut.frame_count;
    step();
    checks++;
    if (missed_count !== 16'hFFFF || frame_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL preload: got %h/%h expected ffff/ffff", missed_count, frame_count);
    end
    VSync = 1'b1;
    step();
    VSync = 1'b0;
    checks++;
    if (missed_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL missed_saturate: got %h expected ffff", missed_count);
    end
    draw_done = 1'b1;
    step();
    draw_done = 1'b0; VSync = 1'b1;
    step();
    VSync = 1'b0;
    checks++;
    if (frame_count !== 16'h0000 || front_sel !== 1'b1 || missed_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL frame_wrap: got frames %h front %b missed %h expected 0000 1 ffff", frame_count, front_sel, missed_count);
    end
  endtask

  // Randomized frames. The bench places every frame on a timeline measured
  // from its boundary cycle (swap edge or reset release): clear occupies
  // offsets 1..N, drawing N+1..N+d, then waiting until the next edge.
  task automatic test_random();
    logic       vs_prev, vs, we;
    logic       e_we, e_ds, e_busy;
    logic [2:0] e_addr;
    logic [8:0] e_data;
    reset = 1'b1; VSync = 1'b0; draw_we = 1'b0; draw_done = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    vs_prev = 1'b0; m_front = 1'b0; m_frames = '0; m_missed = '0;
    e_we = 1'b0; e_ds = 1'b0; e_busy = 1'b1; e_addr = '0; e_data = '0;
    for (int f = 0; f < 12; f++) begin
      int d, gap, total;
      d     = (f == 0) ? 1 : int'($urandom_range(1, 6));
      gap   = int'($urandom_range(0, 3));
      total = N + d + 1 + gap;
      for (int c = 1; c <= total; c++) begin
        step();
        checks++;
        if (fb_we !== e_we || (e_we && (fb_addr !== e_addr || fb_data !== e_data))) begin
          errors++;
          $display("FAIL rnd_fb f%0d c%0d: got %b/%0d/%h expected %b/%0d/%h", f, c, fb_we, fb_addr, fb_data, e_we, e_addr, e_data);
        end
        checks++;
        if (draw_start !== e_ds || busy !== e_busy) begin
          errors++;
          $display("FAIL rnd_ctl f%0d c%0d: got start %b busy %b expected %b %b", f, c, draw_start, busy, e_ds, e_busy);
        end
        checks++;
        if (front_sel !== m_front || frame_count !== m_frames || missed_count !== m_missed) begin
          errors++;
          $display("FAIL rnd_cnt f%0d c%0d: got %b/%0d/%0d expected %b/%0d/%0d", f, c, front_sel, frame_count, missed_count, m_front, m_frames, m_missed);
        end
        vs = ($urandom_range(0, 2) == 0);
        if (c > N + d) vs = (c == total);
        if (c == total - 1) vs = 1'b0;
        we = 1'($urandom_range(0, 1));
        draw_we   = we;
        draw_addr = 3'($urandom);
        draw_data = 9'($urandom);
        if (c > N && c <= N + d) draw_done = (c == N + d);
        else draw_done = 1'($urandom_range(0, 1));
        VSync = vs;
        e_we = 1'b0; e_ds = 1'b0;
        if (c <= N) begin
          e_we = 1'b1; e_addr = 3'(c - 1); e_data = 9'h000; e_ds = (c == N);
          if (vs && !vs_prev && m_missed != 16'hFFFF) m_missed = m_missed + 16'd1;
        end else if (c <= N + d) begin
          if (we) begin
            e_we = 1'b1; e_addr = draw_addr; e_data = draw_data;
          end
          if (vs && !vs_prev && m_missed != 16'hFFFF) m_missed = m_missed + 16'd1;
        end else if (vs && !vs_prev) begin
          m_front  = ~m_front;
          m_frames = m_frames + 16'd1;
        end
        e_busy = (c + 1 <= N + d) || (c == total);
        vs_prev = vs;
      end
    end
    step();
    draw_we = 1'b0; draw_done = 1'b0; VSync = 1'b0;
    checks++;
    if (front_sel !== m_front || frame_count !== m_frames || fb_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rnd_final: got %b/%0d we %b busy %b expected %b/%0d we 0 busy 1", front_sel, frame_count, fb_we, busy, m_front, m_frames);
    end
  endtask

  initial begin
    reset = 1'b1; VSync = 1'b0; draw_done = 1'b0; draw_we = 1'b0;
    draw_addr = '0; draw_data = '0;
    test_reset();
    test_draw_writes();
    test_swap();
    test_missed();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame scheduler for the double-buffered display path. It sits between the LCD VSync, the double buffer and the vertex/raster engine.
- Each frame it clears the back buffer, hands the back-buffer write port to the raster engine and waits for the engine's done signal.
- On the next VSync rising edge after done, it swaps front/back buffers.
- Late frames are counted as missed; no swap occurs for them.

Parameters:
- WIDTH, 800, pixels per line.
- HEIGHT, 480, lines per frame.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- PIX_W, 9, pixel data width.
- CLEAR_COLOR, 0, PIX_W-bit value written to every back-buffer pixel during clear.

Ports:
- clk  in  1  system clock (CLOCK_50 domain); all inputs are synchronous to it.
- reset  in  1  synchronous, active-high reset.
- VSync  in  1  vertical sync level, active-high; a rising edge marks a frame boundary.
- draw_start  out  1  one-cycle pulse telling the raster engine to begin a frame.
- draw_done  in  1  raster engine finished the frame; sampled only in DRAW.
- draw_we  in  1  raster write request.
- draw_addr  in  ADDR_W  raster write address.
- draw_data  in  PIX_W  raster write pixel.
- fb_we  out  1  back-buffer write enable.
- fb_addr  out  ADDR_W  back-buffer write address.
- fb_data  out  PIX_W  back-buffer write data.
- front_sel  out  1  buffer currently scanned out; the back buffer is ~front_sel.
- busy  out  1  high in CLEAR and DRAW.
- frame_count  out  16  completed swaps; wraps modulo 2^16.
- missed_count  out  16  VSync edges seen while not ready; saturates at 16'hFFFF.

Behaviour:
- Reset: state IDLE. front_sel, fb_we, fb_addr, fb_data, draw_start, frame_count, missed_count, the clear counter and vsync_q are all 0. busy is 0.
- Edge detect: vsync_q <= VSync every cycle; edge = VSync & ~vsync_q.
- States and transitions:
  - IDLE -> CLEAR unconditionally on the first cycle out of reset; clear counter <= 0.
  - CLEAR: one write per cycle at counter value k, with addr = k and data = CLEAR_COLOR. After k = WIDTH*HEIGHT-1 -> DRAW.
  - DRAW: fb port is owned by the raster engine. draw_done -> WAIT.
  - WAIT: edge -> SWAP actions (front_sel toggles, frame_count+1, counter <= 0), then -> CLEAR.
- fb port timing:
  - fb_* are registered, 1-cycle latency from the source cycle.
  - CLEAR source is the clear counter; DRAW source is the draw_* inputs.
  - In IDLE and WAIT the registered fb_we is 0; fb_addr/fb_data hold their last values.
  - draw_we outside DRAW is ignored and never reaches fb_we.
- draw_start: registered and high for exactly the first DRAW cycle, which is the same cycle the last clear write is visible on fb_*.
- Swap timing (edge detected in WAIT at cycle T):
  - front_sel toggles and frame_count increments at T+1.
  - First clear write (addr 0) is visible at T+2; last clear write (addr N-1, N = WIDTH*HEIGHT) at T+N+1.
  - draw_start is visible at T+N+1.
- Missed frames:
  - An edge in CLEAR or DRAW increments missed_count (saturating).
  - front_sel does not change and the state machine continues undisturbed.
  - An edge in IDLE is ignored.
- Simultaneous events:
  - draw_we together with draw_done in DRAW: the write is forwarded, then the state moves to WAIT.
  - draw_done in the first DRAW cycle is accepted.
  - A VSync edge in the same cycle draw_done arrives counts as missed; the swap waits for the next edge.
- Reset mid-operation (any state): all registers return to reset values. Any pending clear is abandoned and fb_we is 0 the following cycle.
- busy = (state == CLEAR) | (state == DRAW), registered with state.

Test Plan (WIDTH=4, HEIGHT=2, N=8):
1. Reset 3 cycles, release:
   - fb_we=1 with addr 0..7 and data 0 on 8 consecutive cycles, 2..9 cycles after release.
   - draw_start high exactly one cycle, coincident with addr 7.
   - busy=1 throughout.
2. In DRAW, drive draw_we with addr 5/data 9'h1A3, then addr 2/data 9'h055 on back-to-back cycles:
   - fb_* show the same values one cycle later each.
   - draw_we held high in WAIT produces no fb_we.
3. Drive draw_done, then a VSync 0->1 at cycle T:
   - front_sel 0->1 and frame_count=1 at T+1.
   - Clear addr 0 at T+2, draw_start at T+9.
   - VSync held high for 20 cycles causes no second swap.
4. Raise VSync during CLEAR, then again during DRAW:
   - missed_count=2, front_sel unchanged, clear sequence uninterrupted with addresses 0..7 contiguous.
5. Assert reset at clear address 4:
   - Next cycle: fb_we=0, front_sel=0, both counters 0.
   - Full 0..7 clear restarts after release.
6. Force missed_count to 16'hFFFF via 65535 late edges (or a backdoor preload):
   - Another late edge leaves it at 16'hFFFF.
   - frame_count wraps 16'hFFFF -> 0 on a swap.
